// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-decode handshake bundle for fetch_queue.
// master is the surrounding pipeline, slave is the queue.
interface fetch_queue_if #(parameter int DEPTH = 8);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [31:0]              in_instr;
  logic                     in_adel;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [31:0]              out_instr;
  logic [31:0]              out_pcplus8;
  logic                     out_adel;
  logic [$clog2(DEPTH):0]   count;
  modport master (
    output flush, in_valid, in_pc, in_instr, in_adel, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_pcplus8, out_adel, count
  );
  modport slave (
    input  flush, in_valid, in_pc, in_instr, in_adel, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_pcplus8, out_adel, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch and decode.
// Define FETCHQ_BYPASS_EN to let an empty queue present in_* to decode in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          adel_mem  [DEPTH];
  logic          empty, full, byp, push, pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  // run_q keeps in_ready low during reset and releases it on the first edge after
  assign q.in_ready = run_q & ~full & ~q.flush;
`ifdef FETCHQ_BYPASS_EN
  assign byp = run_q & empty & ~q.flush & q.in_valid;
`else
  assign byp = 1'b0;
`endif
  assign q.out_valid   = ~empty | byp;
  assign q.out_pc      = byp ? q.in_pc    : pc_mem[rd_q];
  assign q.out_instr   = byp ? q.in_instr : instr_mem[rd_q];
  assign q.out_adel    = byp ? q.in_adel  : adel_mem[rd_q];
  assign q.out_pcplus8 = q.out_pc + 32'd8;
  assign q.count       = cnt_q;
  // a bypassed entry consumed the same cycle never touches storage
  assign push = q.in_valid & q.in_ready & ~(byp & q.out_ready);
  assign pop  = ~empty & q.out_ready & ~q.flush;
  always_comb begin
    rd_d  = q.flush ? '0 : rd_q + AW'(pop);
    wr_d  = q.flush ? '0 : wr_q + AW'(push);
    cnt_d = q.flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      run_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= q.in_pc;
      instr_mem[wr_q] <= q.in_instr;
      adel_mem[wr_q]  <= q.in_adel;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference of fetch_queue.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .q(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one cycle: drive at negedge, check against the model, then apply the model's rules at the edge
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ad, input logic rdy, input logic fl);
    logic exp_rdy, exp_valid, byp, acc, pop;
    ent_t head;
    @(negedge clk);
    bus.in_valid = v; bus.in_pc = pc; bus.in_instr = ins; bus.in_adel = ad;
    bus.out_ready = rdy; bus.flush = fl;
    #1;
    exp_rdy = (mq.size() < DEPTH) && !fl;
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = (mq.size() == 0) && v && !fl;
`endif
    exp_valid = (mq.size() > 0) || byp;
    head = byp ? ent_t'{pc, ins, ad} : (mq.size() > 0 ? mq[0] : ent_t'('0));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    chk("count", 64'(bus.count), 64'(mq.size()));
    if (exp_valid) begin
      chk("out_pc", 64'(bus.out_pc), 64'(head.pc));
      chk("out_instr", 64'(bus.out_instr), 64'(head.instr));
      chk("out_adel", 64'(bus.out_adel), 64'(head.adel));
      chk("out_pcplus8", 64'(bus.out_pcplus8), 64'(32'(head.pc + 32'd8)));
    end
    acc = v && exp_rdy;
    pop = rdy && exp_valid && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else if (!(byp && pop)) begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(ent_t'{pc, ins, ad});
    end
  endtask
  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.in_adel = 1'b0; bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    #1 chk("pre_edge_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("resume_in_ready", 64'(bus.in_ready), 64'd1);
    step(1'b1, 32'hBFC00000, 32'h24080001, 1'b0, 1'b0, 1'b0);
    #1;
    chk("first_valid", 64'(bus.out_valid), 64'd1);
    chk("first_pc", 64'(bus.out_pc), 64'hBFC00000);
    chk("first_pcplus8", 64'(bus.out_pcplus8), 64'hBFC00008);
    chk("first_count", 64'(bus.count), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), i[0], 1'b0, 1'b0);
    #1;
    chk("full_count", 64'(bus.count), 64'd8);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    step(1'b1, 32'hDEAD0000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0004, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1 chk("drained_count", 64'(bus.count), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h2000 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + 32'(i * 4), 32'hC0 + 32'(i), i[1], 1'b1, 1'b0);
    #1 chk("steady_count", 64'(bus.count), 64'd3);
    for (int i = 0; i < 2; i++) step(1'b1, 32'h4000 + 32'(i * 4), 32'hD0 + 32'(i), 1'b1, 1'b0, 1'b0);
    #1 chk("preflush_count", 64'(bus.count), 64'd5);
    step(1'b1, 32'h5000, 32'hE0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h6000 + 32'(i * 4), 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_count", 64'(bus.count), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("resume2_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FETCHQ_BYPASS_EN
    step(1'b1, 32'h80000010, 32'h11111111, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h80000014, 32'h22222222, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h80000018, 32'h33333333, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom, $urandom, 1'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
